// File: rtl/top_mem_test.sv
// Memory-to-memory run-length encoder: scans a 32768x64 input SRAM once after reset and
// writes {count,word} records into a 32768x80 output SRAM. Optional macro: LEVEL_SHIFT_EN.

module rle_sram #(
    parameter int DEPTH = 32768,
    parameter int AW    = 15,
    parameter int DW    = 64
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] Mem [0:DEPTH-1];
    logic [DW-1:0] rdata_q;

    // Single port, read data one cycle after address; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) Mem[addr_i] <= wdata_i;
        rdata_q <= Mem[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

module rle_sram_in #(parameter int DEPTH = 32768, parameter int AW = 15, parameter int DW = 64) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] rdata_o
);
    rle_sram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) SRAM32768x64 (
        .clk_i(clk_i), .we_i(1'b0), .addr_i(addr_i), .wdata_i('0), .rdata_o(rdata_o)
    );
endmodule

module rle_mem_in #(parameter int DEPTH = 32768, parameter int AW = 15, parameter int DW = 64) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] rdata_o
);
    rle_sram_in #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) SRAM_syn (
        .clk_i(clk_i), .addr_i(addr_i), .rdata_o(rdata_o)
    );
endmodule

module rle_sram_out #(parameter int DEPTH = 32768, parameter int AW = 15, parameter int RW = 80) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [RW-1:0] wdata_i
);
    logic [RW-1:0] unused_rdata;

    rle_sram #(.DEPTH(DEPTH), .AW(AW), .DW(RW)) SRAM32768x80 (
        .clk_i(clk_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(unused_rdata)
    );
endmodule

module rle_mem_out #(parameter int DEPTH = 32768, parameter int AW = 15, parameter int RW = 80) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [RW-1:0] wdata_i
);
    rle_sram_out #(.DEPTH(DEPTH), .AW(AW), .RW(RW)) SRAM_syn2 (
        .clk_i(clk_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i)
    );
endmodule

module rle_core #(
    parameter int DEPTH = 32768,
    parameter int AW    = 15,
    parameter int DW    = 64,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i
);
    typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DONE} state_t;

    state_t           state_q;
    logic [AW-1:0]    rd_addr_q, out_addr_q, wr_addr_q;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    cur_q;
    logic [CW+DW-1:0] wr_data_q;
    logic             we_q;
    logic [AW:0]      n_rec_q;
    logic [DW-1:0]    word;

`ifdef LEVEL_SHIFT_EN
    assign word = rd_data_i ^ {(DW/8){8'h80}};
`else
    assign word = rd_data_i;
`endif
    assign rd_addr_o = rd_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            out_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cnt_q      <= '0;
            cur_q      <= '0;
            we_q       <= 1'b0;
            n_rec_q    <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE:  state_q <= PRIME;
                PRIME: begin
                    rd_addr_q <= rd_addr_q + AW'(1);
                    state_q   <= RUN;
                end
                RUN: begin
                    rd_addr_q <= rd_addr_q + AW'(1);
                    // rd_addr_q runs one ahead of the word in rd_data_i: 1 = word 0, 0 = last word
                    if (rd_addr_q == AW'(1)) begin
                        cur_q <= word;
                        cnt_q <= CW'(1);
                    end else if (word == cur_q) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        we_q       <= 1'b1;
                        wr_addr_q  <= out_addr_q;
                        wr_data_q  <= {cnt_q, cur_q};
                        out_addr_q <= out_addr_q + AW'(1);
                        cur_q      <= word;
                        cnt_q      <= CW'(1);
                    end
                    if (rd_addr_q == '0) state_q <= FLUSH;
                end
                FLUSH: begin
                    we_q      <= 1'b1;
                    wr_addr_q <= out_addr_q;
                    wr_data_q <= {cnt_q, cur_q};
                    n_rec_q   <= {1'b0, out_addr_q} + (AW+1)'(1);
                    state_q   <= DONE;
                end
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    rle_mem_out #(.DEPTH(DEPTH), .AW(AW), .RW(CW+DW)) MEM_OUT (
        .clk_i(clk), .we_i(we_q), .addr_i(wr_addr_q), .wdata_i(wr_data_q)
    );
endmodule

module top_mem_test #(
    parameter int DEPTH = 32768,
    parameter int AW    = 15,
    parameter int DW    = 64,
    parameter int CW    = 16
) (
    input logic clk,
    input logic reset
);
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    rle_mem_in #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) MEM_IN (
        .clk_i(clk), .addr_i(rd_addr), .rdata_o(rd_data)
    );

    rle_core #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) rl (
        .clk(clk), .reset(reset), .rd_addr_o(rd_addr), .rd_data_i(rd_data)
    );
endmodule

// File: tb/tb_top_mem_test.sv
// Bench for top_mem_test: preloads the input SRAM, lets the encoder run, and compares the
// output SRAM, record count and write timing against a run-grouping reference model.

module tb_top_mem_test;
    localparam int DEPTH = 32768;
    localparam int LIMIT = 32775;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   writes = 0;
    int   last_wr = 0;

    logic [63:0] img [DEPTH];
    logic [79:0] exp_q [$];

    always #5 clk = ~clk;

    top_mem_test dut (.clk(clk), .reset(reset));

    // A write is committed on the rising edge that follows a negedge seeing we_q high.
    always @(negedge clk) begin
        if (reset) begin
            cyc = cyc + 1;
            if (dut.rl.we_q) begin
                writes  = writes + 1;
                last_wr = cyc + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] shift(input logic [63:0] w);
`ifdef LEVEL_SHIFT_EN
        return w ^ 64'h8080_8080_8080_8080;
`else
        return w;
`endif
    endfunction

    // Reference: group consecutive equal (transformed) words into {count, value} records.
    task automatic build_model();
        logic [63:0] cur;
        int          n;
        exp_q.delete();
        cur = shift(img[0]);
        n   = 1;
        for (int i = 1; i < DEPTH; i++) begin
            if (shift(img[i]) == cur) n++;
            else begin
                exp_q.push_back({16'(n), cur});
                cur = shift(img[i]);
                n   = 1;
            end
        end
        exp_q.push_back({16'(n), cur});
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) dut.MEM_IN.SRAM_syn.SRAM32768x64.Mem[i] = img[i];
    endtask

    task automatic enter_reset();
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we",      80'(dut.rl.we_q), 80'd0);
        chk("rst_rd_addr", 80'(dut.rl.rd_addr_q), 80'd0);
        chk("rst_out_addr",80'(dut.rl.out_addr_q), 80'd0);
        chk("rst_cnt",     80'(dut.rl.cnt_q), 80'd0);
        chk("rst_cur",     80'(dut.rl.cur_q), 80'd0);
    endtask

    task automatic release_reset();
        @(negedge clk); #1;
        cyc     = 0;
        writes  = 0;
        last_wr = 0;
        reset   = 1'b1;
    endtask

    task automatic finish_and_check(input string name);
        int snap;
        repeat (LIMIT + 5) @(negedge clk);
        chk({name, "_writes"}, 80'(writes), 80'(exp_q.size()));
        chk({name, "_nrec"}, 80'(dut.rl.n_rec_q), 80'(exp_q.size()));
        chk({name, "_late"}, 80'(last_wr > LIMIT), 80'd0);
        for (int k = 0; k < exp_q.size(); k++)
            chk({name, "_rec"}, dut.rl.MEM_OUT.SRAM_syn2.SRAM32768x80.Mem[k], exp_q[k]);
        snap = writes;
        repeat (100) @(negedge clk);
        chk({name, "_quiet"}, 80'(writes), 80'(snap));
    endtask

    initial begin
        logic [63:0] pool [4];
        logic [63:0] a, c, v;
        int          i, len;

        #3 reset = 1'b0;

        // Image 1: long run, alternating stretch, random short runs, unique last word.
        a = {$urandom, $urandom};
        c = 64'hDEAD_BEEF_0000_0001;
        for (int p = 0; p < 4; p++) pool[p] = {$urandom, $urandom};
        for (i = 0; i < 9000; i++) img[i] = a;
        for (i = 9000; i < 9100; i++) img[i] = i[0] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
        i = 9100;
        while (i < DEPTH - 1) begin
            len = $urandom_range(1, 6);
            v   = pool[$urandom_range(0, 3)];
            for (int j = 0; j < len && i < DEPTH - 1; j++) begin
                img[i] = v;
                i++;
            end
        end
        img[DEPTH-1] = (img[DEPTH-2] == c) ? ~c : c;
        build_model();
        preload();

        // Abort mid-scan, then the restarted scan must produce the full correct output.
        enter_reset();
        release_reset();
        repeat (1000) @(negedge clk);
        enter_reset();
        release_reset();
        finish_and_check("mixed");

        // Image 2: all zero -> one maximal run of 32768.
        for (int k = 0; k < DEPTH; k++) img[k] = 64'd0;
        build_model();
        enter_reset();
        preload();
        release_reset();
        finish_and_check("zero");
        chk("zero_rec0", dut.rl.MEM_OUT.SRAM_syn2.SRAM32768x80.Mem[0], {16'h8000, shift(64'd0)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
